// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: serial RX line plus the program-RAM write bus and status of the UART loader
interface uart_prog_loader_if;
    logic        rx;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        cpu_hold;
    logic        done;
    logic        frame_err;
    modport master (input rx, output ram_we, ram_addr, ram_din, cpu_hold, done, frame_err);
    modport slave (output rx, input ram_we, ram_addr, ram_din, cpu_hold, done, frame_err);
endinterface

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: 8N1 UART receiver that writes a count-prefixed 16-bit program image into RAM
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868
) (
    input logic                clk,
    input logic                rst,
    uart_prog_loader_if.master bus
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 > 0 ? CLKS_PER_BIT / 2 - 1 : 0);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_CNT, L_HI, L_LO, L_WR, L_DONE} ld_state_t;

    logic          rx_meta_q, rx_sync_q;
    rx_state_t     r_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          byte_valid_q, byte_err_q;

    ld_state_t     l_q;
    logic [8:0]    n_q, wcnt_q, wcnt_inc;
    logic          ram_we_q, cpu_hold_q, done_q, frame_err_q;
    logic [7:0]    ram_addr_q;
    logic [15:0]   ram_din_q;

    assign wcnt_inc = wcnt_q + 9'd1;

    // two-flop synchronizer for the asynchronous rx line, idling high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // receiver: find start bit, sample mid-bit, emit one-cycle byte_valid / byte_err
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q          <= R_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
            case (r_q)
                R_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (!rx_sync_q) r_q <= R_START;
                end
                R_START: begin
                    if (cnt_q == MID) begin
                        cnt_q <= '0;
                        r_q   <= rx_sync_q ? R_IDLE : R_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) r_q <= R_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q        <= '0;
                        byte_valid_q <= rx_sync_q;
                        byte_err_q   <= !rx_sync_q;
                        r_q          <= R_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: r_q <= R_IDLE;
            endcase
        end
    end

    // loader: header byte gives word count (0 means 256), then hi/lo byte pairs, one RAM write per pair
    always_ff @(posedge clk) begin
        if (rst) begin
            l_q         <= L_CNT;
            n_q         <= '0;
            wcnt_q      <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (byte_err_q && l_q != L_DONE) begin
            l_q         <= L_CNT;
            ram_we_q    <= 1'b0;
            frame_err_q <= 1'b1;
        end else begin
            case (l_q)
                L_CNT: begin
                    if (byte_valid_q) begin
                        n_q         <= {shift_q == 8'h00, shift_q};
                        wcnt_q      <= '0;
                        ram_addr_q  <= '0;
                        frame_err_q <= 1'b0;
                        l_q         <= L_HI;
                    end
                end
                L_HI: begin
                    if (byte_valid_q) begin
                        ram_din_q[15:8] <= shift_q;
                        l_q             <= L_LO;
                    end
                end
                L_LO: begin
                    if (byte_valid_q) begin
                        ram_din_q[7:0] <= shift_q;
                        ram_we_q       <= 1'b1;
                        l_q            <= L_WR;
                    end
                end
                L_WR: begin
                    ram_we_q <= 1'b0;
                    wcnt_q   <= wcnt_inc;
                    if (wcnt_inc == n_q) begin
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                        l_q        <= L_DONE;
                    end else begin
                        ram_addr_q <= ram_addr_q + 8'd1;
                        l_q        <= L_HI;
                    end
                end
                L_DONE: ;
                default: l_q <= L_CNT;
            endcase
        end
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.done      = done_q;
    assign bus.frame_err = frame_err_q;
endmodule
